// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage: captures the retiring instruction,
// stalls for variable-latency load data, aligns/extends loads and drives the RF write port.
module mem_wb_stage #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             m_valid,
   input  logic             m_rfwr,
   input  logic [4:0]       m_rd,
   input  logic [1:0]       m_wdsel,
   input  logic [31:0]      m_alu_out,
   input  logic [31:0]      m_pc4,
   input  logic [2:0]       m_ldtype,
   input  logic             flush,
   input  logic             dmem_rvalid,
   input  logic [31:0]      dmem_rdata,
   output logic             stall,
   output logic             wb_rfwr,
   output logic [4:0]       wb_rd,
   output logic [31:0]      wb_wd,
   output logic             align_err,
   output logic             bus_err,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   state_t      state_q, state_d;
   logic        p_rfwr;
   logic [4:0]  p_rd;
   logic [2:0]  p_ldtype;
   logic [1:0]  p_lane;
   logic [7:0]  tmo_cnt, cnt_d;

   logic        wr_valid, wr_en, align_set, bus_set, pend_load;
   logic [4:0]  wr_rd;
   logic [31:0] wr_data;

   function automatic logic misaligned(input logic [2:0] lt, input logic [1:0] lane);
      logic is_half, is_byte;
      is_half = (lt == LD_LH) || (lt == LD_LHU);
      is_byte = (lt == LD_LB) || (lt == LD_LBU);
      return (is_half && lane[0]) || (!is_half && !is_byte && (lane != 2'b00));
   endfunction

   function automatic logic [31:0] load_align(input logic [31:0] raw, input logic [2:0] lt,
                                              input logic [1:0] lane);
      logic [7:0]  b;
      logic [15:0] h;
      b = raw[{lane, 3'b000} +: 8];
      h = lane[1] ? raw[31:16] : raw[15:0];
      case (lt)
         LD_LB:   return {{24{b[7]}}, b};
         LD_LH:   return {{16{h[15]}}, h};
         LD_LBU:  return {24'h0, b};
         LD_LHU:  return {16'h0, h};
         default: return raw;
      endcase
   endfunction

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      stall     = 1'b0;
      wr_valid  = 1'b0;
      wr_en     = 1'b0;
      wr_rd     = m_rd;
      wr_data   = m_alu_out;
      align_set = 1'b0;
      bus_set   = 1'b0;
      pend_load = 1'b0;
      cnt_d     = tmo_cnt;
      case (state_q)
         S_IDLE: begin
            if (m_valid && !flush) begin
               if (m_wdsel == 2'b01) begin
                  if (misaligned(m_ldtype, m_alu_out[1:0])) begin
                     align_set = 1'b1;
                  end else if (dmem_rvalid) begin
                     wr_valid = 1'b1;
                     wr_en    = m_rfwr;
                     wr_data  = load_align(dmem_rdata, m_ldtype, m_alu_out[1:0]);
                  end else begin
                     pend_load = 1'b1;
                     cnt_d     = 8'd0;
                     state_d   = S_WAIT;
                  end
               end else begin
                  wr_valid = 1'b1;
                  wr_en    = m_rfwr;
                  wr_data  = (m_wdsel == 2'b10) ? m_pc4 : m_alu_out;
               end
            end
         end
         S_WAIT: begin
            // MEM inputs and flush are ignored here; the load is already committed.
            stall = ~dmem_rvalid;
            if (dmem_rvalid) begin
               wr_valid = 1'b1;
               wr_en    = p_rfwr;
               wr_rd    = p_rd;
               wr_data  = load_align(dmem_rdata, p_ldtype, p_lane);
               state_d  = S_IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               bus_set = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = tmo_cnt + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         p_rfwr    <= 1'b0;
         p_rd      <= 5'd0;
         p_ldtype  <= 3'd0;
         p_lane    <= 2'd0;
         tmo_cnt   <= 8'd0;
         wb_rfwr   <= 1'b0;
         wb_rd     <= 5'd0;
         wb_wd     <= 32'd0;
         align_err <= 1'b0;
         bus_err   <= 1'b0;
         instret   <= '0;
      end else begin
         state_q   <= state_d;
         tmo_cnt   <= cnt_d;
         wb_rfwr   <= wr_valid && wr_en && (wr_rd != 5'd0);
         align_err <= align_set;
         if (bus_set) bus_err <= 1'b1;
         if (wr_valid) begin
            wb_rd   <= wr_rd;
            wb_wd   <= wr_data;
            instret <= instret + CNT_W'(1);
         end
         if (pend_load) begin
            p_rfwr   <= m_rfwr;
            p_rd     <= m_rd;
            p_ldtype <= m_ldtype;
            p_lane   <= m_alu_out[1:0];
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus random traffic,
// compared against a cycle-level behavioural model of the writeback rules.
module tb_mem_wb_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        m_valid, m_rfwr, flush, dmem_rvalid;
   logic [4:0]  m_rd;
   logic [1:0]  m_wdsel;
   logic [31:0] m_alu_out, m_pc4, dmem_rdata;
   logic [2:0]  m_ldtype;
   logic        stall, wb_rfwr, align_err, bus_err;
   logic [4:0]  wb_rd;
   logic [31:0] wb_wd;
   logic [31:0] instret;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   bit          r_wait;
   int          r_waited;
   bit          r_p_rfwr;
   logic [4:0]  r_p_rd;
   logic [2:0]  r_p_lt;
   logic [1:0]  r_p_lane;
   bit          e_rfwr, e_align, e_bus;
   logic [4:0]  e_rd;
   logic [31:0] e_wd;
   logic [31:0] e_instret;

   mem_wb_stage #(.TIMEOUT(TO), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .m_valid(m_valid), .m_rfwr(m_rfwr), .m_rd(m_rd),
      .m_wdsel(m_wdsel), .m_alu_out(m_alu_out), .m_pc4(m_pc4), .m_ldtype(m_ldtype),
      .flush(flush), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .stall(stall), .wb_rfwr(wb_rfwr), .wb_rd(wb_rd), .wb_wd(wb_wd),
      .align_err(align_err), .bus_err(bus_err), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      else n_pass++;
   endtask

   function automatic logic [31:0] ref_align(input logic [31:0] raw, input logic [2:0] lt,
                                             input logic [1:0] lane);
      logic [31:0] v;
      case (lt)
         3'd0, 3'd4: begin
            v = (raw >> (8 * lane)) & 32'hFF;
            if (lt == 3'd0 && v >= 32'h80) v = v - 32'h100;
         end
         3'd1, 3'd5: begin
            v = (lane >= 2 ? raw >> 16 : raw) & 32'hFFFF;
            if (lt == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
         end
         default: v = raw;
      endcase
      return v;
   endfunction

   function automatic bit ref_misaligned(input logic [2:0] lt, input logic [1:0] lane);
      if (lt == 3'd0 || lt == 3'd4) return 1'b0;
      if (lt == 3'd1 || lt == 3'd5) return (lane % 2) != 0;
      return lane != 0;
   endfunction

   task automatic model_reset();
      r_wait = 0; r_waited = 0; r_p_rfwr = 0; r_p_rd = 0; r_p_lt = 0; r_p_lane = 0;
      e_rfwr = 0; e_align = 0; e_bus = 0; e_rd = 0; e_wd = 0; e_instret = 0;
   endtask

   task automatic model_write(input bit we, input logic [4:0] rd, input logic [31:0] data);
      e_rfwr    = we && (rd != 0);
      e_rd      = rd;
      e_wd      = data;
      e_instret = e_instret + 1;
   endtask

   // one clock edge of the reference model, using the inputs present at that edge
   task automatic model_edge();
      e_rfwr  = 0;
      e_align = 0;
      if (r_wait) begin
         if (dmem_rvalid) begin
            model_write(r_p_rfwr, r_p_rd, ref_align(dmem_rdata, r_p_lt, r_p_lane));
            r_wait = 0;
         end else if (r_waited + 1 == TO) begin
            e_bus  = 1;
            r_wait = 0;
         end else begin
            r_waited++;
         end
      end else if (m_valid && !flush) begin
         if (m_wdsel == 2'b01) begin
            if (ref_misaligned(m_ldtype, m_alu_out[1:0])) e_align = 1;
            else if (dmem_rvalid)
               model_write(m_rfwr, m_rd, ref_align(dmem_rdata, m_ldtype, m_alu_out[1:0]));
            else begin
               r_wait = 1; r_waited = 0;
               r_p_rfwr = m_rfwr; r_p_rd = m_rd; r_p_lt = m_ldtype; r_p_lane = m_alu_out[1:0];
            end
         end else begin
            model_write(m_rfwr, m_rd, (m_wdsel == 2'b10) ? m_pc4 : m_alu_out);
         end
      end
   endtask

   task automatic set_in(input bit v, input bit we, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [2:0] lt, input bit fl,
                         input bit rv, input logic [31:0] rdata);
      m_valid = v; m_rfwr = we; m_rd = rd; m_wdsel = sel; m_alu_out = alu;
      m_pc4 = alu + 32'h1000; m_ldtype = lt; flush = fl; dmem_rvalid = rv; dmem_rdata = rdata;
   endtask

   task automatic idle_in();
      set_in(0, 0, 5'd0, 2'b00, 32'h0, 3'd0, 0, 0, 32'h0);
   endtask

   // called at posedge+1; checks stall mid-cycle, then registered outputs after the edge
   task automatic step();
      @(negedge clk);
      check("stall", stall, r_wait && !dmem_rvalid);
      @(posedge clk);
      model_edge();
      #1;
      check("wb_rfwr", wb_rfwr, e_rfwr);
      if (e_rfwr) begin
         check("wb_rd", wb_rd, e_rd);
         check("wb_wd", wb_wd, e_wd);
      end
      check("align_err", align_err, e_align);
      check("bus_err", bus_err, e_bus);
      check("instret", instret, e_instret);
   endtask

   initial begin
      rst = 1'b0;
      idle_in();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_rfwr", wb_rfwr, 1'b0);
      check("rst_wd", wb_wd, 32'h0);
      check("rst_instret", instret, 32'h0);
      check("rst_stall", stall, 1'b0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      // ALU writeback, then the rd=0 variant
      set_in(1, 1, 5'd5, 2'b00, 32'h1234_5678, 3'd2, 0, 0, 32'h0); step();
      check("alu_rfwr", wb_rfwr, 1'b1);
      check("alu_rd", wb_rd, 5'd5);
      check("alu_wd", wb_wd, 32'h1234_5678);
      check("alu_instret", instret, 32'd1);
      set_in(1, 1, 5'd0, 2'b00, 32'h1234_5678, 3'd2, 0, 0, 32'h0); step();
      check("rd0_rfwr", wb_rfwr, 1'b0);

      // same-cycle loads with alignment
      set_in(1, 1, 5'd7, 2'b01, 32'h0000_1003, 3'd0, 0, 1, 32'h80FF_0000); step();
      check("lb_wd", wb_wd, 32'hFFFF_FF80);
      set_in(1, 1, 5'd7, 2'b01, 32'h0000_1003, 3'd4, 0, 1, 32'h80FF_0000); step();
      check("lbu_wd", wb_wd, 32'h0000_0080);
      set_in(1, 1, 5'd7, 2'b01, 32'h0000_1002, 3'd5, 0, 1, 32'h80FF_0000); step();
      check("lhu_wd", wb_wd, 32'h0000_80FF);

      // LW with late data; an ALU op waits behind the stall, then is captured after one bubble
      set_in(1, 1, 5'd9, 2'b01, 32'h0000_2000, 3'd2, 0, 0, 32'h0); step();
      set_in(1, 1, 5'd3, 2'b10, 32'h0000_0040, 3'd0, 0, 0, 32'h0);
      repeat (3) step();
      dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF; step();
      check("lw_late_wd", wb_wd, 32'hDEAD_BEEF);
      check("lw_late_rd", wb_rd, 5'd9);
      dmem_rvalid = 0; step();
      idle_in(); step();

      // misaligned LH, flushed ALU op
      set_in(1, 1, 5'd4, 2'b01, 32'h0000_3001, 3'd1, 0, 1, 32'h1111_2222); step();
      check("mis_align_err", align_err, 1'b1);
      idle_in(); step();
      set_in(1, 1, 5'd6, 2'b00, 32'hCAFE_0000, 3'd0, 1, 0, 32'h0); step();

      // LW that never gets data: timeout, sticky bus_err, late response ignored
      set_in(1, 1, 5'd8, 2'b01, 32'h0000_4000, 3'd2, 0, 0, 32'h0); step();
      idle_in();
      repeat (TO) step();
      check("tmo_bus_err", bus_err, 1'b1);
      dmem_rvalid = 1; dmem_rdata = 32'h5555_AAAA; step();
      idle_in(); step();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         set_in(($urandom % 4) != 0, $urandom % 2,
                ($urandom % 8 == 0) ? 5'd0 : 5'($urandom),
                2'($urandom), $urandom, 3'($urandom), ($urandom % 8) == 0,
                ($urandom % 3) == 0, $urandom);
         step();
      end

      // asynchronous reset while waiting for load data
      idle_in(); step();
      set_in(1, 1, 5'd12, 2'b01, 32'h0000_5000, 3'd2, 0, 0, 32'h0); step();
      idle_in();
      #2;
      check("pre_rst_stall", stall, 1'b1);
      rst = 1'b0;
      #1;
      model_reset();
      check("arst_stall", stall, 1'b0);
      check("arst_rfwr", wb_rfwr, 1'b0);
      check("arst_instret", instret, 32'h0);
      check("arst_bus_err", bus_err, 1'b0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      dmem_rvalid = 1; dmem_rdata = 32'h7777_7777; step();
      idle_in(); step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register and writeback stage for the 5-stage core. It sits directly upstream of the register file and drives its write port (RFWr, A3, WD).
- Captures the retiring instruction from the MEM stage.
- Waits, with a stall, for variable-latency load data from data memory.
- Performs byte/halfword load alignment and sign/zero extension.
- Selects the writeback source and counts retired instructions.

Parameters:
TIMEOUT, 16, max cycles in WAIT before a load is abandoned (range 2..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  core clock; all state updates on posedge
rst  input  1  asynchronous reset, active-low (0 = reset)
m_valid  input  1  MEM stage holds a valid instruction
m_rfwr  input  1  instruction writes a register
m_rd  input  5  destination register
m_wdsel  input  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
m_alu_out  input  32  ALU result / load byte address
m_pc4  input  32  PC+4 of instruction
m_ldtype  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (others = LW)
flush  input  1  squash instruction presented this cycle
dmem_rvalid  input  1  load data valid, one-cycle pulse
dmem_rdata  input  32  raw little-endian word from data memory
stall  output  1  combinational; 1 = hold IF..MEM stages this cycle
wb_rfwr  output  1  register-file write enable (to RFWr)
wb_rd  output  5  write address (to A3)
wb_wd  output  32  write data (to WD)
align_err  output  1  one-cycle pulse: misaligned load dropped
bus_err  output  1  sticky: a load timed out; cleared only by reset
instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset (rst=0, async): state=IDLE; wb_rfwr=0, wb_rd=0, wb_wd=0, align_err=0, bus_err=0, instret=0, timeout counter=0.
- Outputs wb_* are registered. A value captured at posedge k is driven for all of cycle k+1. The register file samples it at the negedge inside cycle k+1, so ID reads in k+1 see the write (write-before-read).
- wb_rfwr is a single-cycle pulse per retiring instruction. It is forced to 0 when rd=0.
- Capture condition in IDLE: m_valid & ~flush.
- Non-load capture (wdsel != 01):
  - wb_wd = ALU or PC+4 per wdsel; wb_rfwr = m_rfwr & (m_rd != 0).
  - instret += 1 (wraps at 2^CNT_W).
- Load capture:
  - Misalign check first: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0. On a misaligned load: no write, align_err=1 next cycle, instret unchanged, stay IDLE.
  - If dmem_rvalid is high in the same cycle: write aligned data next cycle, instret += 1, stay IDLE.
  - Otherwise: latch rd, ldtype and addr[1:0]; go to WAIT; reset the timeout counter.
- Alignment, using lane = addr[1:0]:
  - LB/LBU take byte rdata[8*lane+7:8*lane].
  - LH/LHU take rdata[31:16] if addr[1]=1, else rdata[15:0].
  - Signed types sign-extend; U types zero-extend; LW passes through.
- WAIT state:
  - stall = ~dmem_rvalid; in IDLE stall = 0.
  - MEM inputs are ignored while in WAIT.
  - On dmem_rvalid: write the aligned data with wb_rfwr = latched rfwr & (rd != 0); instret += 1; go to IDLE.
  - The stall drops in this same cycle, so MEM may present the next instruction. It is not captured until the following edge (one bubble).
  - Each cycle without rvalid: counter += 1.
  - When counter = TIMEOUT-1 with no rvalid: bus_err <= 1, no write, instret unchanged, go to IDLE.
  - flush is ignored in WAIT (the load is already committed).
- dmem_rvalid in IDLE with no load being captured: ignored.
- Reset mid-WAIT: immediate return to IDLE with all outputs at their reset values. A pending response arriving later is ignored.

Test Plan:
- ALU op, rd=5, alu_out=0x1234_5678, wdsel=00 -> next cycle wb_rfwr=1, wb_rd=5, wb_wd=0x12345678, instret=1; rd=0 variant -> wb_rfwr=0.
- LB, addr=0x...3, rdata=0x80FF_0000 with rvalid the same cycle -> wb_wd=0xFFFFFF80, no stall; LBU same -> 0x00000080; LHU addr=0x...2 -> 0x000080FF.
- LW, rvalid 3 cycles late, rdata=0xDEADBEEF -> stall high for exactly 3 cycles, then wb_wd=0xDEADBEEF for one cycle; instruction presented during the stall is not captured.
- LH at addr=0x...1 -> align_err pulse 1 cycle, wb_rfwr=0, instret unchanged; flush with an ALU op -> no write.
- LW, TIMEOUT=4, no rvalid -> stall for 4 cycles, then bus_err=1 sticky, wb_rfwr never asserted, state IDLE; a late rvalid is then ignored.
- Assert rst=0 asynchronously mid-WAIT -> stall, wb_rfwr, instret drop to 0 immediately, without waiting for a clock edge.
